limb_lifo: RTL and testbench
============================

// Module: limb_lifo
// PURPOSE
//  Parametrised LIFO for the LIMB core: hardware call stack for CALL/RET and data stack for PUSH/PUSHI/POP.
//  Configurable width and depth, zero-latency top-of-stack peek, simultaneous push+pop (replace top),
//  sticky overflow/underflow flags, sync flush, selectable full-stack policy (reject or overwrite oldest).
//  Sits beside the sequencer; sequencer drives push/pop for one cycle per op and samples top combinationally.
// PARAMETERS
//  DATA_W    8   entry width in bits (8 = PC/data byte)
//  DEPTH     16  entry count; power of two, >= 2
//  OVF_MODE  0   full-stack policy: 0 = reject push on full, 1 = overwrite oldest entry (circular)
//  CNT_W     $clog2(DEPTH)+1  derived; width of count, not overridden
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  push       in   1        write data_in as new top this cycle
//  pop        in   1        remove top this cycle
//  flush      in   1        sync clear of stack contents (pointers only)
//  clr_err    in   1        sync clear of sticky overflow/underflow
//  data_in    in   DATA_W   push data
//  top        out  DATA_W   current top entry; 0 when empty (combinational from state)
//  count      out  CNT_W    valid entries, 0..DEPTH
//  empty      out  1        count == 0
//  full       out  1        count == DEPTH
//  overflow   out  1        sticky: push was rejected (mode 0) or the oldest entry was lost (mode 1)
//  underflow  out  1        sticky: pop attempted while empty
// BEHAVIOUR
//  Reset: wp=0, count=0, overflow=0, underflow=0 -> top=0, empty=1, full=0. Storage array not reset.
//  wp = index of next free slot, modulo DEPTH; top = mem[wp-1 mod DEPTH] when count!=0, else 0.
//  All updates on rising clk; top/count/flags reflect new state the cycle after the op (1-cycle latency).
//  Priority per cycle: flush > push/pop. flush: wp=0, count=0; flags unchanged unless clr_err also high.
//  push only, count<DEPTH: mem[wp]<=data_in, wp++, count++.
//  push only, full, OVF_MODE=0: no write, no pointer change, overflow<=1.
//  push only, full, OVF_MODE=1: mem[wp]<=data_in (overwrites oldest), wp++, count stays DEPTH, overflow<=1.
//  pop only, count>0: wp--, count--. Entry contents are not cleared.
//  pop only, empty: no change, underflow<=1.
//  push+pop, count>0 (incl. full): replace top: mem[wp-1]<=data_in; wp, count unchanged; no flag set.
//  push+pop, empty: pop rejected (underflow<=1), push performed as push-only (count becomes 1).
//  clr_err: overflow<=0, underflow<=0, unless an error event occurs in the same cycle: that event wins (flag=1).
//  Pointer arithmetic wraps modulo DEPTH (low $clog2(DEPTH) bits); count never exceeds DEPTH or drops below 0.
//  Reset asserted mid-operation: all state returns to reset values immediately; in-flight op is lost.
//  No X on top: when empty, top is forced to 0 regardless of stale memory.
// STRUCTURE
//  limb_pkg: typedef enum logic {OVF_REJECT=1'b0, OVF_OVERWRITE=1'b1} limb_ovf_mode_e; LIMB_DATA_W=8 constant.
//  OVF_MODE typed as limb_ovf_mode_e. Storage as one sub-module limb_lifo_ram (1W/1R async-read,
//  DEPTH x DATA_W, no reset); pointer/count/flag control stays in limb_lifo.
//  Elaboration check: $error if DEPTH is not a power of two or DEPTH<2.
// TESTING
//  1 Reset, then push 8'h11,8'h22,8'h33 -> top=33, count=3; pop x3 -> tops 22,11,0; empty=1, no flags.
//  2 DEPTH=4, mode 0: push 1..5 -> 5th rejected, count=4, top=4, overflow=1; pop x4 -> 4,3,2,1 order.
//  3 DEPTH=4, mode 1: push 1..6 -> count=4, top=6, overflow=1; pop x4 yields 6,5,4,3; then empty.
//  4 Stack {AA,BB}: push+pop with 8'hCC -> count=2, top=CC; pop -> top=AA. Empty: push+pop 8'h55 -> count=1, top=55, underflow=1.
//  5 Pop when empty -> underflow=1, count=0; clr_err alone -> flags 0; clr_err + pop-on-empty same cycle -> underflow=1.
//  6 count=3, flush -> count=0, top=0, flags held; assert reset mid-push burst -> count=0, flags 0, top=0 next cycle.

Source files
------------

// File: rtl/limb_lifo_pkg.sv
// limb_pkg: shared types and constants for the LIMB stack
package limb_pkg;
  typedef enum logic {OVF_REJECT = 1'b0, OVF_OVERWRITE = 1'b1} limb_ovf_mode_e;
  localparam int LIMB_DATA_W = 8;
  function automatic bit limb_pow2(input int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/limb_lifo_if.sv
// limb_lifo_if: sequencer-to-stack command and status bundle
interface limb_lifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              push;
  logic              pop;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  modport master (output push, pop, flush, clr_err, data_in, input top, count, empty, full, overflow, underflow);
  modport slave  (input push, pop, flush, clr_err, data_in, output top, count, empty, full, overflow, underflow);
endinterface

// File: rtl/limb_lifo_ram.sv
// limb_lifo_ram: 1W/1R async-read storage, deliberately without reset
module limb_lifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // single write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/limb_lifo.sv
// limb_lifo: call/data stack with replace-top, sticky error flags and selectable full policy
module limb_lifo
  import limb_pkg::*;
#(
  parameter int             DATA_W   = LIMB_DATA_W,
  parameter int             DEPTH    = 16,
  parameter limb_ovf_mode_e OVF_MODE = OVF_REJECT,
  parameter int             CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic      clk,
  input  logic      reset,
  limb_lifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  if (!limb_pow2(DEPTH)) begin : g_bad_depth
    $error("limb_lifo: DEPTH must be a power of two and >= 2");
  end
  logic [AW-1:0]     wp, wp_nxt, wr_addr, tp;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf, unf, ovf_nxt, unf_nxt;
  logic              do_push, do_pop, is_empty, is_full, rep, pu, po, adv, wr_en;
  logic [DATA_W-1:0] rd_data;
  // decode the cycle's operation and compute next pointer, count and flags
  always_comb begin
    do_push  = bus.push && !bus.flush;
    do_pop   = bus.pop && !bus.flush;
    is_empty = cnt == '0;
    is_full  = cnt == CNT_W'(DEPTH);
    tp       = wp - 1'b1;
    rep      = do_push && do_pop && !is_empty;
    pu       = do_push && !rep;
    po       = do_pop && !do_push && !is_empty;
    adv      = pu && (!is_full || OVF_MODE == OVF_OVERWRITE);
    wr_en    = rep || adv;
    wr_addr  = rep ? tp : wp;
    wp_nxt   = bus.flush ? '0 : adv ? wp + 1'b1 : po ? tp : wp;
    cnt_nxt  = bus.flush ? '0 : (pu && !is_full) ? cnt + 1'b1 : po ? cnt - 1'b1 : cnt;
    ovf_nxt  = (pu && is_full) || (ovf && !bus.clr_err);
    unf_nxt  = (do_pop && is_empty) || (unf && !bus.clr_err);
  end
  // state registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      wp  <= wp_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  limb_lifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (bus.data_in),
    .raddr (tp),
    .rdata (rd_data)
  );
  assign bus.top       = is_empty ? '0 : rd_data;
  assign bus.count     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_limb_lifo.sv
// tb_limb_lifo: three stack configurations driven in lockstep against queue models
module tb_limb_lifo;
  import limb_pkg::*;
  logic       clk = 1'b0, reset = 1'b1;
  logic       push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;
  int         n_cmp = 0, n_err = 0;
  int         q [3][$];
  bit         m_ovf [3], m_unf [3];
  int         dep [3] = '{16, 4, 4};
  bit         ow [3] = '{1'b0, 1'b0, 1'b1};
  always #5 clk = ~clk;
  limb_lifo_if #(.DATA_W(8), .CNT_W(5)) b0 ();
  limb_lifo_if #(.DATA_W(8), .CNT_W(3)) b1 ();
  limb_lifo_if #(.DATA_W(8), .CNT_W(3)) b2 ();
  assign b0.push = push, b0.pop = pop, b0.flush = flush, b0.clr_err = clr_err, b0.data_in = din;
  assign b1.push = push, b1.pop = pop, b1.flush = flush, b1.clr_err = clr_err, b1.data_in = din;
  assign b2.push = push, b2.pop = pop, b2.flush = flush, b2.clr_err = clr_err, b2.data_in = din;
  limb_lifo #(.DATA_W(8), .DEPTH(16), .OVF_MODE(OVF_REJECT))    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  limb_lifo #(.DATA_W(8), .DEPTH(4),  .OVF_MODE(OVF_REJECT))    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  limb_lifo #(.DATA_W(8), .DEPTH(4),  .OVF_MODE(OVF_OVERWRITE)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input int k, input int t, input int c, input int e, input int f, input int o, input int u);
    int sz = q[k].size();
    chk($sformatf("d%0d top", k), t, sz == 0 ? 0 : q[k][sz-1]);
    chk($sformatf("d%0d count", k), c, sz);
    chk($sformatf("d%0d empty", k), e, int'(sz == 0));
    chk($sformatf("d%0d full", k), f, int'(sz == dep[k]));
    chk($sformatf("d%0d overflow", k), o, int'(m_ovf[k]));
    chk($sformatf("d%0d underflow", k), u, int'(m_unf[k]));
  endtask

  task automatic check_all();
    chk_dut(0, int'(b0.top), int'(b0.count), int'(b0.empty), int'(b0.full), int'(b0.overflow), int'(b0.underflow));
    chk_dut(1, int'(b1.top), int'(b1.count), int'(b1.empty), int'(b1.full), int'(b1.overflow), int'(b1.underflow));
    chk_dut(2, int'(b2.top), int'(b2.count), int'(b2.empty), int'(b2.full), int'(b2.overflow), int'(b2.underflow));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
  endtask

  task automatic model_op(input int k, input bit p, input bit o, input bit f, input bit c, input int d);
    bit eo = 1'b0, eu = 1'b0;
    if (f) q[k].delete();
    else if (p && o && q[k].size() > 0) q[k][q[k].size()-1] = d;
    else begin
      if (o && q[k].size() == 0) eu = 1'b1;
      else if (o && !p) void'(q[k].pop_back());
      if (p) begin
        if (q[k].size() == dep[k]) begin
          eo = 1'b1;
          if (ow[k]) begin
            void'(q[k].pop_front());
            q[k].push_back(d);
          end
        end else q[k].push_back(d);
      end
    end
    if (c) begin
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
    m_ovf[k] |= eo;
    m_unf[k] |= eu;
  endtask

  task automatic step(input bit p, input bit o, input bit f, input bit c, input logic [7:0] d);
    push = p;
    pop = o;
    flush = f;
    clr_err = c;
    din = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_op(k, p, o, f, c, int'(d));
    #1;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    chk("t1 top33", int'(b0.top), 'h33);
    repeat (3) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 8'(i));
    chk("t2 rej top", int'(b1.top), 4);
    chk("t2 rej ovf", int'(b1.overflow), 1);
    chk("t2 ow top", int'(b2.top), 5);
    repeat (4) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    for (int i = 1; i <= 6; i++) step(1, 0, 0, 0, 8'(i));
    chk("t3 ow top", int'(b2.top), 6);
    chk("t3 ow cnt", int'(b2.count), 4);
    repeat (5) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    step(1, 0, 0, 0, 8'hAA);
    step(1, 0, 0, 0, 8'hBB);
    step(1, 1, 0, 0, 8'hCC);
    chk("t4 replace top", int'(b0.top), 'hCC);
    step(0, 1, 0, 0, 8'h00);
    chk("t4 pop top", int'(b0.top), 'hAA);
    step(0, 0, 1, 0, 8'h00);
    step(1, 1, 0, 0, 8'h55);
    chk("t4 empty pp unf", int'(b0.underflow), 1);
    step(0, 0, 1, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    chk("t5 clr vs event", int'(b0.underflow), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    step(0, 0, 1, 0, 8'h00);
    chk("t6 flush keeps unf", int'(b0.underflow), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
    push = 1'b1;
    din = 8'h77;
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    push = 1'b0;
    reset = 1'b0;
    check_all();
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      step(r < 55, (r >= 35 && r < 85), $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
